pipe_ctrl: RTL and testbench
============================

Name: pipe_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARM core (IF, ID, EX, MEM, WB).
- Generates the freeze and flush controls that are currently tied off at the top level:
  - `hazard_stall`: freezes IF and IF_Reg, and bubbles ID_Reg.
  - `flush`: clears IF_Reg and ID_Reg on a taken branch.
  - `mem_freeze`: freezes every stage while a multi-cycle data-memory access completes.
- Also keeps saturating performance counters for stalls, flushes and memory wait cycles.

Parameters:
- WAIT_CYCLES, 4, number of cycles `mem_freeze` is held per data-memory access (legal range ≥1).
- CNT_W, 16, width of each performance counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  synchronous reset, active-low.
- src1  in  4  ID-stage Rn address.
- src2  in  4  ID-stage second-source address (Rm or Rd for STR).
- two_src  in  1  ID instruction reads `src2`.
- ex_dest  in  4  EX-stage destination register.
- ex_wb_en  in  1  EX instruction writes back.
- ex_mem_r_en  in  1  EX instruction is a load.
- mem_dest  in  4  MEM-stage destination register.
- mem_wb_en  in  1  MEM instruction writes back.
- mem_req  in  1  MEM-stage instruction is a load or store (MEM_R_EN|MEM_W_EN).
- forward_en  in  1  forwarding unit active.
- branch_taken  in  1  EX-stage branch resolved taken.
- cnt_clr  in  1  synchronous clear of all counters.
- hazard_stall  out  1  freeze IF/IF_Reg, bubble ID_Reg.
- flush  out  1  clear IF_Reg and ID_Reg.
- mem_freeze  out  1  freeze all pipeline registers and the PC.
- mem_busy  out  1  memory FSM not in IDLE.
- stall_cnt  out  CNT_W  cycles with `hazard_stall`=1.
- flush_cnt  out  CNT_W  cycles with `flush`=1.
- memwait_cnt  out  CNT_W  cycles with `mem_freeze`=1.

Behaviour:
- Reset (RST=0 at a clock edge):
  - FSM goes to IDLE and the wait counter clears.
  - All three performance counters clear to 0.
  - Outputs are therefore 0 in the following cycle, provided the combinational inputs are 0.
  - Reset mid-access aborts the access; `mem_freeze` drops in the cycle after the reset edge.
- Raw hazard (combinational):
  - `match1` = `src1`==`ex_dest` & `ex_wb_en`.
  - `match2` = `two_src` & `src2`==`ex_dest` & `ex_wb_en`.
  - `mmatch1` / `mmatch2` are the same comparisons against `mem_dest` / `mem_wb_en`.
  - `forward_en`=0: raw = `match1` | `match2` | `mmatch1` | `mmatch2`.
  - `forward_en`=1: raw = `ex_mem_r_en` & (`match1` | `match2`), i.e. load-use only.
- Priority is `mem_freeze` > `flush` > `hazard_stall`:
  - `flush` = `branch_taken` & ~`mem_freeze`.
  - `hazard_stall` = raw & ~`branch_taken` & ~`mem_freeze`.
  - Consequence: a branch held in EX during a freeze flushes exactly once, in the cycle the pipeline advances.
- Memory FSM (states IDLE, BUSY, DONE; wait counter `wcnt` is `$clog2(WAIT_CYCLES+1)` bits):
  - IDLE, `mem_req`=0: stay in IDLE; `mem_freeze`=0.
  - IDLE, `mem_req`=1: `mem_freeze`=1 combinationally in the same cycle.
    - WAIT_CYCLES=1: next state DONE.
    - Otherwise: next state BUSY, `wcnt`←1.
  - BUSY: `mem_freeze`=1.
    - `wcnt`==WAIT_CYCLES-1: next state DONE.
    - Otherwise: `wcnt`++.
  - DONE: `mem_freeze`=0 for exactly one cycle, so the completed instruction leaves MEM.
    - `mem_req` is ignored in this cycle.
    - Next state IDLE.
  - Net effect: exactly WAIT_CYCLES frozen cycles per access.
  - Back-to-back memory instructions: IDLE, 4×freeze, DONE, IDLE with new `mem_req` → freeze again. Minimum one released cycle between accesses.
  - `mem_busy` = state≠IDLE.
- Counters:
  - Each counter increments by 1 per cycle in which its output is 1.
  - Saturate at 2^CNT_W−1 (no wrap).
  - `cnt_clr` has priority over increment; the counter reads 0 in the next cycle.
  - RST has priority over everything.

Decomposition:
- Shared package `arm_pkg`:
  - FSM state typedef (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Register-address width constant (4).
- One sub-module, `sat_counter` (parameter W; inputs clk, rst_n, clr, inc; output q), instantiated three times.
- Hazard compare and FSM stay inline.

Test Plan:
- Hazard, no forwarding: `forward_en`=0, `ex_wb_en`=1, `ex_dest`=3, `src1`=3 → `hazard_stall`=1 that cycle. Then `src1`=5, `two_src`=0 → `hazard_stall`=0.
- Load-use with forwarding: `forward_en`=1, `ex_mem_r_en`=1, `ex_dest`=2, `two_src`=1, `src2`=2 → `hazard_stall`=1. Then `ex_mem_r_en`=0 → `hazard_stall`=0. A MEM match alone → 0.
- Branch over hazard: `branch_taken`=1 with a raw hazard present → `flush`=1, `hazard_stall`=0. `flush_cnt` increments by 1.
- Memory wait (WAIT_CYCLES=4): `mem_req` held high → `mem_freeze`=1 for 4 consecutive cycles, then 0 for 1 cycle (DONE), then 1 again. `memwait_cnt`=4 after the first access.
- Branch during freeze: `branch_taken`=1 while `mem_freeze`=1 → `flush`=0 throughout the freeze, `flush`=1 in the DONE cycle only.
- Reset and clear: RST=0 mid-BUSY → next cycle `mem_busy`=0, `mem_freeze`=0 (with `mem_req`=0), counters 0. Counters preset near 0xFFFF saturate at 0xFFFF. `cnt_clr`=1 → 0.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared definitions for the ARM core pipeline control logic.
package arm_pkg;

  localparam int REG_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low reset and synchronous clear.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc && (q != '1)) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: hazard stall, branch flush, data-memory freeze
// and saturating performance counters for the 5-stage ARM core.
module pipe_ctrl
  import arm_pkg::*;
#(
  parameter int WAIT_CYCLES = 4,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [REG_W-1:0] src1,
  input  logic [REG_W-1:0] src2,
  input  logic             two_src,
  input  logic [REG_W-1:0] ex_dest,
  input  logic             ex_wb_en,
  input  logic             ex_mem_r_en,
  input  logic [REG_W-1:0] mem_dest,
  input  logic             mem_wb_en,
  input  logic             mem_req,
  input  logic             forward_en,
  input  logic             branch_taken,
  input  logic             cnt_clr,
  output logic             hazard_stall,
  output logic             flush,
  output logic             mem_freeze,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WCW = $clog2(WAIT_CYCLES + 1);

  mem_state_t     state;
  logic [WCW-1:0] wcnt;

  logic match1, match2, mmatch1, mmatch2, raw;

  always_comb begin
    match1  = (src1 == ex_dest) && ex_wb_en;
    match2  = two_src && (src2 == ex_dest) && ex_wb_en;
    mmatch1 = (src1 == mem_dest) && mem_wb_en;
    mmatch2 = two_src && (src2 == mem_dest) && mem_wb_en;
    if (forward_en) begin
      raw = ex_mem_r_en && (match1 || match2);
    end else begin
      raw = match1 || match2 || mmatch1 || mmatch2;
    end
  end

  // Freeze asserts in the request cycle itself so the access costs exactly WAIT_CYCLES.
  always_comb begin
    mem_freeze = 1'b0;
    case (state)
      IDLE:    mem_freeze = mem_req;
      BUSY:    mem_freeze = 1'b1;
      default: mem_freeze = 1'b0;
    endcase
  end

  assign mem_busy     = (state != IDLE);
  assign flush        = branch_taken && !mem_freeze;
  assign hazard_stall = raw && !branch_taken && !mem_freeze;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state <= IDLE;
      wcnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_req) begin
            if (WAIT_CYCLES == 1) begin
              state <= DONE;
            end else begin
              state <= BUSY;
              wcnt  <= WCW'(1);
            end
          end
        end
        BUSY: begin
          if (wcnt == WCW'(WAIT_CYCLES - 1)) begin
            state <= DONE;
          end else begin
            wcnt <= wcnt + WCW'(1);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (cnt_clr),
    .inc   (hazard_stall),
    .q     (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (cnt_clr),
    .inc   (flush),
    .q     (flush_cnt)
  );

  sat_counter #(.W(CNT_W)) u_memwait_cnt (
    .clk   (CLK),
    .rst_n (RST),
    .clr   (cnt_clr),
    .inc   (mem_freeze),
    .q     (memwait_cnt)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: driver queues expected outputs per cycle, monitor checks on negedge.
module tb_pipe_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic [3:0] src1, src2, ex_dest, mem_dest;
  logic       two_src, ex_wb_en, ex_mem_r_en, mem_wb_en, mem_req;
  logic       forward_en, branch_taken, cnt_clr;

  logic        hazard_stall, flush, mem_freeze, mem_busy;
  logic [15:0] stall_cnt, flush_cnt, memwait_cnt;
  logic        s_hazard_stall, s_flush, s_mem_freeze, s_mem_busy;
  logic [3:0]  s_stall_cnt, s_flush_cnt, s_memwait_cnt;

  always #5 CLK = ~CLK;

  pipe_ctrl #(.WAIT_CYCLES(4), .CNT_W(16)) dut (
    .CLK(CLK), .RST(RST), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .forward_en(forward_en), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .hazard_stall(hazard_stall), .flush(flush), .mem_freeze(mem_freeze),
    .mem_busy(mem_busy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
    .memwait_cnt(memwait_cnt)
  );

  // Narrow-counter copy so saturation is reachable in a few cycles.
  pipe_ctrl #(.WAIT_CYCLES(4), .CNT_W(4)) dut_s (
    .CLK(CLK), .RST(RST), .src1(src1), .src2(src2), .two_src(two_src),
    .ex_dest(ex_dest), .ex_wb_en(ex_wb_en), .ex_mem_r_en(ex_mem_r_en),
    .mem_dest(mem_dest), .mem_wb_en(mem_wb_en), .mem_req(mem_req),
    .forward_en(forward_en), .branch_taken(branch_taken), .cnt_clr(cnt_clr),
    .hazard_stall(s_hazard_stall), .flush(s_flush), .mem_freeze(s_mem_freeze),
    .mem_busy(s_mem_busy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt),
    .memwait_cnt(s_memwait_cnt)
  );

  typedef struct {
    string       name;
    logic        h, f, m, b;
    logic [15:0] sc, fc, mc;
    logic [3:0]  ssc, sfc, smc;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  logic [15:0] m_sc = '0, m_fc = '0, m_mc = '0;
  logic [3:0]  m_ssc = '0, m_sfc = '0, m_smc = '0;

  task automatic cmp(input string nm, input string fld, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s.%s: got %0d expected %0d", nm, fld, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t r;
      r = q.pop_front();
      cmp(r.name, "hazard_stall", int'(hazard_stall), int'(r.h));
      cmp(r.name, "flush",        int'(flush),        int'(r.f));
      cmp(r.name, "mem_freeze",   int'(mem_freeze),   int'(r.m));
      cmp(r.name, "mem_busy",     int'(mem_busy),     int'(r.b));
      cmp(r.name, "stall_cnt",    int'(stall_cnt),    int'(r.sc));
      cmp(r.name, "flush_cnt",    int'(flush_cnt),    int'(r.fc));
      cmp(r.name, "memwait_cnt",  int'(memwait_cnt),  int'(r.mc));
      cmp(r.name, "s_stall_cnt",  int'(s_stall_cnt),  int'(r.ssc));
      cmp(r.name, "s_flush_cnt",  int'(s_flush_cnt),  int'(r.sfc));
      cmp(r.name, "s_memwait_cnt", int'(s_memwait_cnt), int'(r.smc));
    end
  end

  // Queue this cycle's expectation, advance the counter model, move to the next cycle.
  task automatic chk(input string nm, input logic h, input logic f, input logic m, input logic b);
    exp_t e;
    e.name = nm; e.h = h; e.f = f; e.m = m; e.b = b;
    e.sc = m_sc; e.fc = m_fc; e.mc = m_mc;
    e.ssc = m_ssc; e.sfc = m_sfc; e.smc = m_smc;
    q.push_back(e);
    if (!RST || cnt_clr) begin
      m_sc = '0; m_fc = '0; m_mc = '0;
      m_ssc = '0; m_sfc = '0; m_smc = '0;
    end else begin
      if (h && m_sc  != 16'hFFFF) m_sc  = m_sc + 16'd1;
      if (f && m_fc  != 16'hFFFF) m_fc  = m_fc + 16'd1;
      if (m && m_mc  != 16'hFFFF) m_mc  = m_mc + 16'd1;
      if (h && m_ssc != 4'hF)     m_ssc = m_ssc + 4'd1;
      if (f && m_sfc != 4'hF)     m_sfc = m_sfc + 4'd1;
      if (m && m_smc != 4'hF)     m_smc = m_smc + 4'd1;
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_inputs();
    src1 = '0; src2 = '0; ex_dest = '0; mem_dest = '0;
    two_src = 0; ex_wb_en = 0; ex_mem_r_en = 0; mem_wb_en = 0;
    mem_req = 0; forward_en = 0; branch_taken = 0; cnt_clr = 0;
  endtask

  initial begin
    RST = 1'b0;
    idle_inputs();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    chk("reset_state", 0, 0, 0, 0);

    forward_en = 0; ex_wb_en = 1; ex_dest = 4'd3; src1 = 4'd3;
    chk("raw_ex_src1", 1, 0, 0, 0);
    src1 = 4'd5; two_src = 0;
    chk("no_match", 0, 0, 0, 0);

    forward_en = 1; ex_mem_r_en = 1; ex_dest = 4'd2; two_src = 1; src2 = 4'd2; src1 = 4'd7;
    chk("load_use_src2", 1, 0, 0, 0);
    ex_mem_r_en = 0;
    chk("fwd_no_load", 0, 0, 0, 0);
    ex_mem_r_en = 1; ex_dest = 4'd9; two_src = 0; mem_dest = 4'd7; mem_wb_en = 1;
    chk("fwd_mem_only", 0, 0, 0, 0);
    forward_en = 0;
    chk("raw_mem_src1", 1, 0, 0, 0);
    src1 = 4'd4; src2 = 4'd9; two_src = 0; mem_wb_en = 0;
    chk("src2_unused", 0, 0, 0, 0);

    src1 = 4'd9; branch_taken = 1;
    chk("branch_over_raw", 0, 1, 0, 0);
    idle_inputs();
    chk("after_branch", 0, 0, 0, 0);

    mem_req = 1;
    chk("acc1_c0", 0, 0, 1, 0);
    chk("acc1_c1", 0, 0, 1, 1);
    chk("acc1_c2", 0, 0, 1, 1);
    chk("acc1_c3", 0, 0, 1, 1);
    chk("acc1_done", 0, 0, 0, 1);
    branch_taken = 1; ex_wb_en = 1; ex_dest = 4'd6; src1 = 4'd6;
    chk("acc2_c0_br", 0, 0, 1, 0);
    mem_req = 0;
    chk("acc2_c1_br", 0, 0, 1, 1);
    chk("acc2_c2_br", 0, 0, 1, 1);
    chk("acc2_c3_br", 0, 0, 1, 1);
    chk("acc2_done_br", 0, 1, 0, 1);
    idle_inputs();
    chk("acc2_idle", 0, 0, 0, 0);

    mem_req = 1;
    chk("acc3_c0", 0, 0, 1, 0);
    mem_req = 0; RST = 0;
    chk("acc3_rst", 0, 0, 1, 1);
    RST = 1;
    chk("post_reset", 0, 0, 0, 0);

    ex_wb_en = 1; ex_dest = 4'd1; src1 = 4'd1;
    for (int i = 0; i < 18; i++) chk("sat_hold", 1, 0, 0, 0);
    cnt_clr = 1;
    chk("clr_over_inc", 1, 0, 0, 0);
    cnt_clr = 0;
    chk("after_clr", 1, 0, 0, 0);
    idle_inputs();
    chk("final_idle", 0, 0, 0, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    if (q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
